freq_gate_meter: RTL and testbench
==================================

FREQ_GATE_METER -- requirements
Module: freq_gate_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, clk cycles per gate window (1 ms at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  measurement enable.
REQ-005 SHALL have port cnt_in  input  16  free-running edge count from the upstream edge counter, already in the clk domain.
REQ-006 SHALL have port freq_out  output  16  edges per gate window.
REQ-007 SHALL have port freq_valid  output  1  freq_out holds an unconsumed result.
REQ-008 SHALL have port freq_ready  input  1  consumer accepts the result when freq_valid is high.
REQ-009 SHALL have port overrun  output  1  sticky flag: a result was overwritten before it was accepted.

Function
REQ-010 SHALL implement FSM states IDLE, PRIME, RUN.
REQ-011 SHALL go IDLE->PRIME when en=1 and PRIME->RUN on the first gate tick; any state ->IDLE when en=0.
REQ-012 SHALL keep gate counter gcnt, range 0..GATE_CYCLES-1, incrementing each cycle in PRIME/RUN and wrapping to 0; gate tick = (gcnt==GATE_CYCLES-1).
REQ-013 SHALL hold gcnt at 0 in IDLE, so the first tick after en rises comes exactly GATE_CYCLES cycles later.
REQ-014 SHALL, on every tick in PRIME or RUN, load prev_cnt <= cnt_in.
REQ-015 SHALL, on a tick in PRIME, produce no result (priming only).
REQ-016 SHALL, on a tick in RUN, compute delta = cnt_in - prev_cnt modulo 2^16, so a 16-bit wrap of cnt_in is handled transparently.
REQ-017 SHALL register the result: freq_out updates and freq_valid is high on the cycle after the tick (latency 1).
REQ-018 SHALL keep freq_valid and freq_out stable until a cycle with freq_valid=1 and freq_ready=1 (transfer); freq_valid SHALL be 0 on the following cycle unless a new result is loaded.
REQ-019 SHALL, if a new result and a transfer occur in the same cycle, load the new result, keep freq_valid=1, and leave overrun unchanged.
REQ-020 SHALL, if a new result arrives while freq_valid=1 and freq_ready=0, overwrite freq_out with the new value and set overrun=1.
REQ-021 SHALL keep overrun set until rst.
REQ-022 SHALL, on en falling, leave freq_out/freq_valid unchanged and keep honouring the handshake; a re-enable SHALL pass through PRIME again.
REQ-023 SHALL ignore freq_ready when freq_valid=0.

Reset
REQ-024 SHALL, when rst=1 at a clk edge, force state=IDLE, gcnt=0, prev_cnt=0, freq_out=0, freq_valid=0, overrun=0, and accumulator=0 and sub-count=0 where present.
REQ-025 SHALL give rst priority over en, ticks and handshake; rst mid-gate discards the partial window.

Configuration
REQ-026 SHALL, with macro FREQ_AVG_EN defined, accumulate 4 consecutive RUN deltas in an 18-bit sum and emit a result only on every 4th delta, with freq_out = sum[17:2] (truncating), then clear the sum.
REQ-027 SHALL restart the 4-delta group on PRIME entry and on rst when FREQ_AVG_EN is defined.
REQ-028 SHALL, with FREQ_AVG_EN undefined, emit one result per RUN tick (delta direct) and contain no accumulator logic.

Verification (bench GATE_CYCLES=100)
REQ-029 SHALL cover reset: rst high 3 cycles, en=1 -> freq_out=0, freq_valid=0, overrun=0 throughout reset.
REQ-030 SHALL cover steady rate: cnt_in +7 per gate, freq_ready=1 -> no valid for the priming gate, then freq_out=7 with freq_valid high exactly 1 cycle, 1 cycle after each tick.
REQ-031 SHALL cover wrap: prev_cnt=0xFFFA, cnt_in=0x0005 at the tick -> freq_out=11.
REQ-032 SHALL cover overrun: freq_ready=0 across two RUN ticks with deltas 5 then 9 -> freq_out=9, overrun=1; freq_ready=1 -> freq_valid drops next cycle, overrun stays 1.
REQ-033 SHALL cover en drop: en=0 at gcnt=50 then re-raised -> gcnt restarts at 0, the next tick is priming (no valid), and the following tick gives a correct delta.
REQ-034 SHALL cover FREQ_AVG_EN: deltas 10,12,14,16 -> single result freq_out=13 after the 4th tick, with no valid pulse on ticks 1-3.

Source files
------------

// File: rtl/freq_gate_meter.sv
// Gate-window frequency meter: differences a free-running edge count over fixed gate windows.
// Optional FREQ_AVG_EN macro averages four consecutive window deltas into one result.
module freq_gate_meter #(
  parameter int GATE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] cnt_in,
  output logic [15:0] freq_out,
  output logic        freq_valid,
  input  logic        freq_ready,
  output logic        overrun
);
  localparam int DATA_W = 16;
  localparam int GW     = $clog2(GATE_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  // Modulo-2^16 difference absorbs a wrap of the upstream counter.
  function automatic logic [DATA_W-1:0] wrap_delta(input logic [DATA_W-1:0] now_v,
                                                   input logic [DATA_W-1:0] then_v);
    return now_v - then_v;
  endfunction

`ifdef FREQ_AVG_EN
  function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W+1:0] sum_v);
    return sum_v[DATA_W+1:2];
  endfunction
`endif

  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [DATA_W-1:0] prev_cnt_q, prev_cnt_d;
  logic [DATA_W-1:0] freq_out_q, freq_out_d;
  logic              freq_valid_q, freq_valid_d;
  logic              overrun_q, overrun_d;
  logic              tick, new_res;
  logic [DATA_W-1:0] delta, res_val;
`ifdef FREQ_AVG_EN
  logic [DATA_W+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]        sub_q, sub_d;
`endif

  always_comb begin
    state_d      = state_q;
    gcnt_d       = gcnt_q;
    prev_cnt_d   = prev_cnt_q;
    freq_out_d   = freq_out_q;
    freq_valid_d = freq_valid_q;
    overrun_d    = overrun_q;
    new_res      = 1'b0;
    res_val      = '0;
    delta        = wrap_delta(cnt_in, prev_cnt_q);
    tick         = (state_q != S_IDLE) && (gcnt_q == GW'(GATE_CYCLES - 1));
`ifdef FREQ_AVG_EN
    acc_d        = acc_q;
    sub_d        = sub_q;
    acc_sum      = acc_q + {2'b00, delta};
`endif

    if (!en) begin
      state_d = S_IDLE;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PRIME;
          gcnt_d  = '0;
`ifdef FREQ_AVG_EN
          acc_d   = '0;
          sub_d   = 2'd0;
`endif
        end
        S_PRIME: begin
          gcnt_d = tick ? '0 : gcnt_q + 1'b1;
          if (tick) begin
            prev_cnt_d = cnt_in;
            state_d    = S_RUN;
          end
        end
        S_RUN: begin
          gcnt_d = tick ? '0 : gcnt_q + 1'b1;
          if (tick) begin
            prev_cnt_d = cnt_in;
`ifdef FREQ_AVG_EN
            if (sub_q == 2'd3) begin
              new_res = 1'b1;
              res_val = avg4(acc_sum);
              acc_d   = '0;
              sub_d   = 2'd0;
            end else begin
              acc_d = acc_sum;
              sub_d = sub_q + 2'd1;
            end
`else
            new_res = 1'b1;
            res_val = delta;
`endif
          end
        end
        default: begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end
      endcase
    end

    // A fresh result always wins; it only flags overrun if the old one was still pending.
    if (new_res) begin
      if (freq_valid_q && !freq_ready) overrun_d = 1'b1;
      freq_out_d   = res_val;
      freq_valid_d = 1'b1;
    end else if (freq_valid_q && freq_ready) begin
      freq_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gcnt_q       <= '0;
      prev_cnt_q   <= '0;
      freq_out_q   <= '0;
      freq_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FREQ_AVG_EN
      acc_q        <= '0;
      sub_q        <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      gcnt_q       <= gcnt_d;
      prev_cnt_q   <= prev_cnt_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      overrun_q    <= overrun_d;
`ifdef FREQ_AVG_EN
      acc_q        <= acc_d;
      sub_q        <= sub_d;
`endif
    end
  end

  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_freq_gate_meter.sv
// Bench for freq_gate_meter (GATE_CYCLES=100): directed phases with randomized count jumps,
// checked every cycle against a gate-arithmetic reference model.
module tb_freq_gate_meter;
  localparam int GC = 100;

  logic        clk = 1'b0;
  logic        rst, en, freq_ready, freq_valid, overrun;
  logic [15:0] cnt_in, freq_out;
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic        m_valid, m_ovr;
  logic [15:0] m_out, m_prev;
  bit          m_act;
  int          m_ncyc, m_nticks, m_grp;
  int unsigned m_sum;

  always #5 clk = ~clk;

  freq_gate_meter #(.GATE_CYCLES(GC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt_in    (cnt_in),
    .freq_out  (freq_out),
    .freq_valid(freq_valid),
    .freq_ready(freq_ready),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predicts the effect of the coming rising edge from the inputs now being driven.
  task automatic predict();
    logic        newres;
    logic [15:0] val, d;
    newres = 1'b0;
    val    = '0;
    if (rst) begin
      m_act = 0; m_valid = 0; m_out = 0; m_ovr = 0; m_prev = 0; m_sum = 0; m_grp = 0;
      return;
    end
    if (!en) m_act = 0;
    else if (!m_act) begin
      m_act = 1; m_ncyc = 0; m_nticks = 0; m_sum = 0; m_grp = 0;
    end else begin
      m_ncyc++;
      if (m_ncyc % GC == 0) begin
        m_nticks++;
        d = cnt_in - m_prev;
        if (m_nticks >= 2) begin
`ifdef FREQ_AVG_EN
          m_sum += d;
          m_grp++;
          if (m_grp == 4) begin
            newres = 1'b1;
            val    = 16'(m_sum / 4);
            m_sum  = 0;
            m_grp  = 0;
          end
`else
          newres = 1'b1;
          val    = d;
`endif
        end
        m_prev = cnt_in;
      end
    end
    if (newres) begin
      if (m_valid && !freq_ready) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_out   = val;
    end else if (m_valid && freq_ready) m_valid = 1'b0;
  endtask

  task automatic cyc(input logic r, input logic e, input logic rdy, input logic [15:0] add,
                     input string tag);
    rst        = r;
    en         = e;
    freq_ready = rdy;
    cnt_in     = cnt_in + add;
    predict();
    @(negedge clk);
    check({tag, "_valid"}, 16'(freq_valid), 16'(m_valid));
    check({tag, "_ovr"}, 16'(overrun), 16'(m_ovr));
    check({tag, "_out"}, freq_out, m_out);
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random ready
  task automatic gates(input int n, input logic [15:0] amt, input int rmode, input string tag);
    for (int g = 0; g < n; g++) begin
      int p = $urandom_range(10, 80);
      for (int i = 0; i < GC; i++)
        cyc(1'b0, 1'b1, (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode),
            (i == p) ? amt : 16'd0, tag);
    end
  endtask

  initial begin
    logic [15:0] amt;
    cnt_in = 16'h0123;
    m_valid = 0; m_ovr = 0; m_out = 0; m_prev = 0; m_act = 0;
    m_ncyc = 0; m_nticks = 0; m_grp = 0; m_sum = 0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 16'd3, "reset");

`ifndef FREQ_AVG_EN
    cyc(1'b0, 1'b1, 1'b1, 16'd0, "en_rise");
    gates(4, 16'd7, 1, "steady");
    check("steady_7", freq_out, 16'd7);

    amt = 16'hFFFA - cnt_in;
    gates(1, amt, 1, "wrap_pre");
    gates(1, 16'd11, 1, "wrap");
    check("wrap_11", freq_out, 16'd11);

    gates(1, 16'd5, 0, "ovr_a");
    gates(1, 16'd9, 0, "ovr_b");
    check("ovr_out9", freq_out, 16'd9);
    check("ovr_flag", 16'(overrun), 16'd1);
    cyc(1'b0, 1'b1, 1'b1, 16'd0, "ovr_ack");
    check("ovr_drop", 16'(freq_valid), 16'd0);
    check("ovr_sticky", 16'(overrun), 16'd1);

    for (int i = 0; i < 49; i++) cyc(1'b0, 1'b1, 1'b1, 16'(i % 2), "pre_drop");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'd2, "en_low");
    cyc(1'b0, 1'b1, 1'b1, 16'd0, "re_en");
    gates(2, 16'd4, 1, "reprime");
    check("reprime_4", freq_out, 16'd4);

    for (int g = 0; g < 6; g++) gates(1, 16'($urandom_range(0, 65535)), 2, "rand");

    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b1, 16'd1, "mid_gate");
    cyc(1'b1, 1'b1, 1'b1, 16'd0, "rst_mid");
    check("rst_mid_ovr", 16'(overrun), 16'd0);
    check("rst_mid_out", freq_out, 16'd0);
    cyc(1'b0, 1'b1, 1'b1, 16'd0, "after_rst");
    gates(2, 16'd21, 1, "recover");
    check("recover_21", freq_out, 16'd21);
`else
    cyc(1'b0, 1'b1, 1'b1, 16'd0, "en_rise");
    gates(1, 16'd5, 1, "avg_prime");
    gates(1, 16'd10, 1, "avg_d1");
    gates(1, 16'd12, 1, "avg_d2");
    gates(1, 16'd14, 1, "avg_d3");
    check("avg_none", 16'(freq_valid), 16'd0);
    gates(1, 16'd16, 1, "avg_d4");
    check("avg_13", freq_out, 16'd13);
    check("avg_valid", 16'(freq_valid), 16'd1);
    for (int g = 0; g < 8; g++) gates(1, 16'($urandom_range(0, 65535)), 2, "avg_rand");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
